// File: rtl/rpm_setpoint_ramp.sv
// rpm_setpoint_ramp
// Per-channel setpoint bank with slew-rate limiting. Each decoded UART write
// sets a channel target; on every prescaled tick each channel's ramped
// setpoint moves toward its target by at most STEP, so the downstream PID
// loops never see a step change.
// Optional feature: define SETPOINT_CLAMP_EN to saturate incoming targets to
// [-RPM_MAX, +RPM_MAX] before they are stored.
module rpm_setpoint_ramp #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_CHN    = 4,
   parameter int CHN_WIDTH  = 3,
   parameter int TICK_DIV   = 50000,
   parameter int STEP       = 20,
   parameter int RPM_MAX    = 3000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          tr_valid_i,
   input  logic [CHN_WIDTH-1:0]          tr_chn_i,
   input  logic [DATA_WIDTH-1:0]         tr_data_i,
   output logic [NUM_CHN*DATA_WIDTH-1:0] sp_o,
   output logic                          sp_upd_o,
   output logic [NUM_CHN-1:0]            settled_o,
   output logic                          err_chn_o
);

   localparam int                  CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
   localparam logic [DATA_WIDTH:0] STEP_W   = (DATA_WIDTH+1)'(STEP);
   localparam logic [DATA_WIDTH:0] ONE_W    = (DATA_WIDTH+1)'(1);
   localparam logic [DATA_WIDTH-1:0] STEP_D = DATA_WIDTH'(STEP);

`ifdef SETPOINT_CLAMP_EN
   localparam logic [DATA_WIDTH-1:0] RPM_HI = DATA_WIDTH'(RPM_MAX);
   localparam logic [DATA_WIDTH-1:0] RPM_LO = DATA_WIDTH'(-RPM_MAX);
`endif

   // Saturate an incoming target (identity when clamping is not built in).
   function automatic logic [DATA_WIDTH-1:0] clamp_fn(input logic [DATA_WIDTH-1:0] v);
`ifdef SETPOINT_CLAMP_EN
      logic [DATA_WIDTH-1:0] res;
      if ($signed(v) > $signed(RPM_HI)) begin
         res = RPM_HI;
      end else if ($signed(v) < $signed(RPM_LO)) begin
         res = RPM_LO;
      end else begin
         res = v;
      end
      return res;
`else
      return v;
`endif
   endfunction

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] tgt_q [NUM_CHN];
   logic [DATA_WIDTH-1:0] tgt_d [NUM_CHN];
   logic [DATA_WIDTH-1:0] sp_q  [NUM_CHN];
   logic [DATA_WIDTH-1:0] sp_d  [NUM_CHN];
   logic                  sp_upd_q, sp_upd_d;
   logic                  err_chn_q, err_chn_d;

   logic                  tick_s;
   logic                  chn_ok_s;
   logic                  wr_ok_s;
   logic                  chg_s;
   logic [DATA_WIDTH:0]   diff_s [NUM_CHN];
   logic [DATA_WIDTH:0]   mag_s  [NUM_CHN];

   // Tick strobe and write qualification.
   always_comb begin
      tick_s   = (cnt_q == CNT_LAST);
      chn_ok_s = ({{(32-CHN_WIDTH){1'b0}}, tr_chn_i} < 32'(NUM_CHN));
      wr_ok_s  = tr_valid_i & chn_ok_s;
   end

   // Free-running prescaler, wraps after the tick cycle.
   always_comb begin
      if (tick_s) begin
         cnt_d = {CNT_W{1'b0}};
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Signed distance to target (one extra bit so it never overflows) and its magnitude.
   always_comb begin
      for (int c = 0; c < NUM_CHN; c++) begin
         diff_s[c] = {tgt_q[c][DATA_WIDTH-1], tgt_q[c]} - {sp_q[c][DATA_WIDTH-1], sp_q[c]};
         if (diff_s[c][DATA_WIDTH]) begin
            mag_s[c] = ~diff_s[c] + ONE_W;
         end else begin
            mag_s[c] = diff_s[c];
         end
      end
   end

   // Ramp step on the tick using the current targets; snaps when within one step.
   always_comb begin
      chg_s = 1'b0;
      for (int c = 0; c < NUM_CHN; c++) begin
         sp_d[c] = sp_q[c];
         if (tick_s) begin
            if (mag_s[c] <= STEP_W) begin
               sp_d[c] = tgt_q[c];
            end else if (!diff_s[c][DATA_WIDTH]) begin
               sp_d[c] = sp_q[c] + STEP_D;
            end else begin
               sp_d[c] = sp_q[c] - STEP_D;
            end
         end else begin
            sp_d[c] = sp_q[c];
         end
         if (sp_d[c] != sp_q[c]) begin
            chg_s = 1'b1;
         end else begin
            chg_s = chg_s;
         end
      end
      sp_upd_d = tick_s & chg_s;
   end

   // Target bank write; a simultaneous tick already stepped toward the old target.
   always_comb begin
      for (int c = 0; c < NUM_CHN; c++) begin
         if (wr_ok_s && (tr_chn_i == CHN_WIDTH'(c))) begin
            tgt_d[c] = clamp_fn(tr_data_i);
         end else begin
            tgt_d[c] = tgt_q[c];
         end
      end
      err_chn_d = tr_valid_i & ~chn_ok_s;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= {CNT_W{1'b0}};
         sp_upd_q  <= 1'b0;
         err_chn_q <= 1'b0;
         for (int c = 0; c < NUM_CHN; c++) begin
            tgt_q[c] <= {DATA_WIDTH{1'b0}};
            sp_q[c]  <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         cnt_q     <= cnt_d;
         sp_upd_q  <= sp_upd_d;
         err_chn_q <= err_chn_d;
         for (int c = 0; c < NUM_CHN; c++) begin
            tgt_q[c] <= tgt_d[c];
            sp_q[c]  <= sp_d[c];
         end
      end
   end

   // Output packing and per-channel settled compare.
   always_comb begin
      for (int c = 0; c < NUM_CHN; c++) begin
         sp_o[c*DATA_WIDTH +: DATA_WIDTH] = sp_q[c];
         settled_o[c]                     = (sp_q[c] == tgt_q[c]);
      end
      sp_upd_o  = sp_upd_q;
      err_chn_o = err_chn_q;
   end

endmodule

// File: doc/rpm_setpoint_ramp.md
# rpm_setpoint_ramp

Per-channel setpoint bank and slew-rate limiter sitting directly downstream of the UART command decoder. Captures each decoded (channel, target RPM) write, stores it as that channel's target, and steps a ramped setpoint toward the target by a fixed amount per prescaled tick. The ramped setpoints feed the per-motor PID loops, so a new UART command never applies a step change to a motor.

## Interface
- DATA_WIDTH, 16: width of signed RPM values, two's complement.
- NUM_CHN, 4: number of motor channels (1..8).
- CHN_WIDTH, 3: channel index width; matches the decoder's channel field.
- TICK_DIV, 50000: clk cycles per ramp tick (≥2).
- STEP, 20: maximum setpoint change per tick (unsigned, ≥1, < 2^(DATA_WIDTH-1)).
- RPM_MAX, 3000: saturation magnitude used only when SETPOINT_CLAMP_EN is defined.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tr_valid_i  in  1  one-cycle write strobe from the decoder.
- tr_chn_i  in  CHN_WIDTH  target channel of the write.
- tr_data_i  in  DATA_WIDTH  signed target RPM.
- sp_o  out  NUM_CHN*DATA_WIDTH  ramped setpoints; channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- sp_upd_o  out  1  one-cycle pulse: sp_o changed on this ramp tick.
- settled_o  out  NUM_CHN  bit c high when setpoint c equals target c.
- err_chn_o  out  1  one-cycle pulse: write to a channel ≥ NUM_CHN was dropped.

## Operation
- Reset: all targets 0, all setpoints 0, tick counter 0, sp_upd_o 0, err_chn_o 0; settled_o therefore all ones.
- Write path: on a clk edge with tr_valid_i=1 and tr_chn_i<NUM_CHN, target[tr_chn_i] ← tr_data_i (after clamping, if enabled). Other targets are unchanged.
- Invalid channel: tr_chn_i≥NUM_CHN leaves all state unchanged. err_chn_o=1 for exactly the following cycle.
- Tick counter: counts 0..TICK_DIV-1 and wraps. The tick is asserted in the cycle where count==TICK_DIV-1. The counter runs freely and is not affected by writes.
- Ramp step, applied on the tick edge to every channel in parallel:
  - diff = target − setpoint, computed in DATA_WIDTH+1 bits so it cannot overflow.
  - If |diff| ≤ STEP: setpoint ← target.
  - Else if diff>0: setpoint ← setpoint+STEP.
  - Else: setpoint ← setpoint−STEP.
  - The step never overshoots and never wraps, including ramps between −2^(DATA_WIDTH-1) and 2^(DATA_WIDTH-1)−1.
- sp_upd_o: registered. High for the one cycle following a tick edge at which at least one setpoint changed.
- settled_o[c]: combinational compare of the registered setpoint[c] and target[c].
- Retargeting mid-ramp: the ramp continues from the current setpoint toward the new target. There is no restart and no jump.

## Timing
- Write at edge N: target visible from cycle N+1. settled_o drops in cycle N+1 if the new target differs from the setpoint.
- Write and tick at the same edge: that tick steps toward the old target. The new target takes effect on the next tick.
- Ramp of distance D completes in ceil(D/STEP) ticks. The first step happens at the first tick edge after the write.
- Back-to-back writes (every cycle) are accepted. The last write to a channel before a tick wins.
- rst asserted mid-ramp: at the next edge all state returns to reset values regardless of tr_valid_i or tick; no write in that cycle is taken.

## Configuration
- SETPOINT_CLAMP_EN defined: tr_data_i is saturated to [−RPM_MAX, +RPM_MAX] before being stored as the target.
- SETPOINT_CLAMP_EN undefined: tr_data_i is stored unmodified and RPM_MAX is ignored.

## Test plan
- Reset, then write ch1=1000 with TICK_DIV=4, STEP=100 -> sp ch1 rises 100,200,…,1000 on successive ticks; settled_o[1] returns high after the 10th tick; sp_upd_o pulses 10 times.
- Write ch2=−250, STEP=100 -> setpoints −100, −200, −250 (no overshoot); settled_o[2]=1 after the 3rd tick.
- Write ch0=500 and, when sp ch0=300, write ch0=100 -> setpoint goes 300→200→100 and stops there.
- Write with tr_chn_i=5, NUM_CHN=4 -> err_chn_o high for 1 cycle; all targets, setpoints and settled_o unchanged.
- Write ch3=−5000 with SETPOINT_CLAMP_EN and RPM_MAX=3000 -> target −3000, ramp ends at −3000; without the macro the ramp ends at −5000.
- Assert rst for 1 cycle mid-ramp (sp ch1=400, target 1000) -> next cycle all sp_o=0, settled_o=all ones, no further sp_upd_o pulses.
